// File: rtl/uart_frame_host.sv
//------------------------------------------------------------------------------
// Module   : uart_frame_host
// Purpose  : Streams one IMG_SIZE x IMG_SIZE frame of pixel bytes from a
//            frame buffer to a UART transmitter in address order, then waits
//            for a single ASCII digit reply from the UART receiver and reports
//            the predicted digit together with a status code.
// Ports    : clk, reset        - clock and synchronous active-high reset
//            start_i           - one-cycle frame request (IDLE only)
//            rd_addr_o/rd_en_o - frame-buffer read port (1-cycle read latency)
//            rd_data_i         - pixel byte returned by the frame buffer
//            tx_dv_o/tx_byte_o - byte strobe and data to the UART transmitter
//            tx_busy_i         - UART transmitter busy
//            rx_dv_i/rx_byte_i - byte strobe and data from the UART receiver
//            busy_o/done_o     - transaction active / one-cycle end pulse
//            digit_o/err_o     - predicted digit / status (00 ok, 01 timeout,
//                                10 non-digit reply)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_frame_host #(
  parameter int IMG_SIZE       = 28,
  parameter int ADDR_WIDTH     = 10,     // 2**ADDR_WIDTH must cover IMG_SIZE**2
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic                  rd_en_o,
  input  logic [7:0]            rd_data_i,
  output logic                  tx_dv_o,
  output logic [7:0]            tx_byte_o,
  input  logic                  tx_busy_i,
  input  logic                  rx_dv_i,
  input  logic [7:0]            rx_byte_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [3:0]            digit_o,
  output logic [1:0]            err_o
);

  localparam int N     = IMG_SIZE * IMG_SIZE;
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N - 1);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_BADBYTE = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SEND,
    S_WAIT_ACK,
    S_WAIT_TX,
    S_WAIT_RESP,
    S_FIN
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [7:0]              tx_byte_q, tx_byte_d;
  logic [3:0]              digit_q, digit_d;
  logic [1:0]              err_q, err_d;

  // ASCII '0'..'9' are 0x30..0x39, so the low nibble is already the digit.
  logic w_is_digit;
  assign w_is_digit = (rx_byte_i >= 8'h30) && (rx_byte_i <= 8'h39);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      tx_byte_q <= 8'h00;
      digit_q   <= 4'h0;
      err_q     <= ERR_OK;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      tx_byte_q <= tx_byte_d;
      digit_q   <= digit_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    tx_byte_d = tx_byte_q;
    digit_d   = digit_q;
    err_d     = err_q;
    rd_en_o   = 1'b0;
    tx_dv_o   = 1'b0;
    done_o    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          idx_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        rd_en_o = 1'b1;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        // Read data for the FETCH-cycle address arrives here.
        tx_byte_d = rd_data_i;
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (!tx_busy_i) begin
          tx_dv_o = 1'b1;
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        // tx_busy only rises one cycle after tx_dv; skip that blind cycle.
        state_d = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (!tx_busy_i) begin
          if (idx_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = S_WAIT_RESP;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_WAIT_RESP: begin
        cnt_d = cnt_q + 1'b1;
        // A reply in the final counter cycle still counts as a reply.
        if (rx_dv_i) begin
          if (w_is_digit) begin
            digit_d = rx_byte_i[3:0];
            err_d   = ERR_OK;
          end else begin
            err_d   = ERR_BADBYTE;
          end
          state_d = S_FIN;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_o    = (state_q != S_IDLE);
  assign rd_addr_o = idx_q;
  assign tx_byte_o = tx_byte_q;
  assign digit_o   = digit_q;
  assign err_o     = err_q;

endmodule

`default_nettype wire
